// File: rtl/cla_adder_pipe.sv
// Pipelined two-level carry-lookahead adder/subtractor with a valid/ready elastic pipeline.
//
// GROUP-bit lookahead cells produce group generate/propagate terms. A group-level
// lookahead turns these into group carries, and each cell expands its own in-group carries
// from its group carry-in.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat this cycle (combinational from out_ready)
//   in_a/in_b  operands
//   in_cin     carry-in (add) / borrow-in (sub)
//   in_sub     0 = add, 1 = subtract
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out_sum    result, modulo 2^WIDTH
//   out_carry  carry-out (add) / borrow-out (sub)
//   out_ovf    signed overflow
//   out_zero   out_sum == 0
//   out_neg    out_sum[WIDTH-1]
module cla_adder_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned GROUP  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int unsigned NGRP = WIDTH / GROUP;

  if ((WIDTH % GROUP) != 0) begin : g_bad_width
    $error("cla_adder_pipe: WIDTH must be a multiple of GROUP");
  end
  if (GROUP != 2 && GROUP != 4 && GROUP != 8) begin : g_bad_group
    $error("cla_adder_pipe: GROUP must be 2, 4 or 8");
  end
  if (STAGES != 1 && STAGES != 2) begin : g_bad_stages
    $error("cla_adder_pipe: STAGES must be 1 or 2");
  end

  // Operand conditioning and bit/group generate-propagate.
  logic [WIDTH-1:0] b_cond;
  logic [WIDTH-1:0] p_a;
  logic [WIDTH-1:0] g_a;
  logic [NGRP-1:0]  gg_a;
  logic [NGRP-1:0]  gp_a;
  logic             c0_a;
  logic             term;

  always_comb begin
    b_cond = in_sub ? ~in_b : in_b;
    c0_a   = in_sub ? ~in_cin : in_cin;
    p_a    = in_a ^ b_cond;
    g_a    = in_a & b_cond;
    gg_a   = '0;
    gp_a   = '1;
    term   = 1'b0;
    for (int k = 0; k < int'(NGRP); k++) begin
      for (int j = 0; j < int'(GROUP); j++) begin
        // g[j] survives to the group output only if every higher bit propagates.
        term = g_a[k*GROUP+j];
        for (int m = j + 1; m < int'(GROUP); m++) begin
          term = term & p_a[k*GROUP+m];
        end
        gg_a[k] = gg_a[k] | term;
        gp_a[k] = gp_a[k] & p_a[k*GROUP+j];
      end
    end
  end

  // Operands seen by the carry/sum stage.
  logic [WIDTH-1:0] s2_p;
  logic [WIDTH-1:0] s2_g;
  logic [NGRP-1:0]  s2_gg;
  logic [NGRP-1:0]  s2_gp;
  logic             s2_c0;
  logic             s2_sub;
  logic             s2_valid;
  logic             out_adv;

  assign out_adv = !out_valid || out_ready;

  if (STAGES == 2) begin : g_two_stage
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] g_q;
    logic [NGRP-1:0]  gg_q;
    logic [NGRP-1:0]  gp_q;
    logic             c0_q;
    logic             sub_q;
    logic             v_q;
    logic             adv;

    assign adv      = !v_q || out_adv;
    assign in_ready = adv;

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= in_valid;
        if (in_valid) begin
          p_q   <= p_a;
          g_q   <= g_a;
          gg_q  <= gg_a;
          gp_q  <= gp_a;
          c0_q  <= c0_a;
          sub_q <= in_sub;
        end
      end
    end

    assign s2_p     = p_q;
    assign s2_g     = g_q;
    assign s2_gg    = gg_q;
    assign s2_gp    = gp_q;
    assign s2_c0    = c0_q;
    assign s2_sub   = sub_q;
    assign s2_valid = v_q;
  end else begin : g_one_stage
    assign in_ready = out_adv;
    assign s2_p     = p_a;
    assign s2_g     = g_a;
    assign s2_gg    = gg_a;
    assign s2_gp    = gp_a;
    assign s2_c0    = c0_a;
    assign s2_sub   = in_sub;
    assign s2_valid = in_valid;
  end

  // Carries, sum and flags. carry_in[WIDTH] is the carry out of the MSB.
  logic [NGRP:0]    grp_c;
  logic [WIDTH:0]   carry_in;
  logic [WIDTH-1:0] sum_c;
  logic             acc;
  logic             prod;
  logic             carry_flag;
  logic             ovf_flag;

  always_comb begin
    grp_c    = '0;
    carry_in = '0;
    acc      = 1'b0;
    prod     = 1'b0;
    grp_c[0] = s2_c0;
    // Group carries, each expanded directly from GG/GP and c0 rather than rippled.
    for (int k = 0; k < int'(NGRP); k++) begin
      acc  = s2_gg[k];
      prod = s2_gp[k];
      for (int j = k - 1; j >= 0; j--) begin
        acc  = acc | (prod & s2_gg[j]);
        prod = prod & s2_gp[j];
      end
      grp_c[k+1] = acc | (prod & s2_c0);
    end
    // In-group carries expanded from the group carry-in.
    for (int k = 0; k < int'(NGRP); k++) begin
      for (int j = 0; j < int'(GROUP); j++) begin
        acc  = 1'b0;
        prod = 1'b1;
        for (int m = j - 1; m >= 0; m--) begin
          acc  = acc | (prod & s2_g[k*GROUP+m]);
          prod = prod & s2_p[k*GROUP+m];
        end
        carry_in[k*GROUP+j] = acc | (prod & grp_c[k]);
      end
    end
    carry_in[WIDTH] = grp_c[NGRP];
  end

  assign sum_c      = s2_p ^ carry_in[WIDTH-1:0];
  assign carry_flag = s2_sub ? ~carry_in[WIDTH] : carry_in[WIDTH];
  assign ovf_flag   = carry_in[WIDTH-1] ^ carry_in[WIDTH];

  // Output register holds its beat while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
    end else if (out_adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_sum   <= sum_c;
        out_carry <= carry_flag;
        out_ovf   <= ovf_flag;
        out_zero  <= (sum_c == '0);
        out_neg   <= sum_c[WIDTH-1];
      end
    end
  end

endmodule
